// File: rtl/switch_port_rx_pkg.sv
// rtl/switch_port_rx_pkg.sv - shared types, header offsets and helpers for the switch egress receiver
package switch_port_rx_pkg;

    localparam int DEF_PACKET_WIDTH = 16;
    localparam int DEF_DEPTH        = 8;
    localparam int NUM_PORTS        = 4;

    localparam int SRC_LSB     = 0;
    localparam int TGT_LSB     = 4;
    localparam int PAYLOAD_LSB = 8;

    typedef enum logic [1:0] {
        PKT_DATA     = 2'b00,
        PKT_CTRL     = 2'b01,
        PKT_MGMT     = 2'b10,
        PKT_RESERVED = 2'b11
    } pkt_type_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rx_state_e;

    // Only meaningful for a one-hot input; callers gate on the source check.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_port_rx_if.sv
// rtl/switch_port_rx_if.sv - valid/ready packet stream carrying a packet and its 2-bit type
interface switch_port_rx_if
    import switch_port_rx_pkg::*;
#(
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH
) ();
    logic                    tvalid;
    logic                    tready;
    logic [PACKET_WIDTH-1:0] tdata;
    logic [1:0]              tuser;

    modport master (output tvalid, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/switch_port_rx_fifo.sv
// rtl/switch_port_rx_fifo.sv - first-word-fall-through egress queue with flush and occupancy count
module switch_port_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign valid     = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Flush takes priority over any push or pop landing on the same edge.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && valid && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/switch_port_rx.sv
// rtl/switch_port_rx.sv - egress receiver: legality checks, FWFT buffering and delivery statistics
module switch_port_rx
    import switch_port_rx_pkg::*;
#(
    parameter int PORT_ID      = 0,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    switch_port_rx_if.slave             rx,
    switch_port_rx_if.master            out,
    input  logic                        flush_req,
    input  logic                        stat_clr,
    output logic [4*CNT_WIDTH-1:0]      src_cnt,
    output logic [CNT_WIDTH-1:0]        drop_cnt,
    output logic [CNT_WIDTH-1:0]        err_cnt,
    output logic                        err_misroute,
    output logic                        err_src,
    output logic                        err_type,
    output logic [$clog2(DEPTH):0]      fifo_count
);
    localparam int QW = PACKET_WIDTH + 2;

    rx_state_e                        state_q, state_d;
    logic                             live_q, live_d;
    logic [3:0][CNT_WIDTH-1:0]        src_cnt_q, src_cnt_d;
    logic [CNT_WIDTH-1:0]             drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0]             err_cnt_q, err_cnt_d;
    logic                             err_misroute_q, err_misroute_d;
    logic                             err_src_q, err_src_d;
    logic                             err_type_q, err_type_d;

    logic            fifo_full, fifo_valid;
    logic [QW-1:0]   fifo_head;
    logic            accept, drop_ev, push, pop;
    logic            bad_route, bad_src, bad_type, legal;
    logic [1:0]      src_idx;

    // live_q keeps rx_ready low for the cycle following reset.
    assign live_d    = 1'b1;
    assign rx.tready = live_q && (state_q == RUN) && !fifo_full;
    assign accept    = rx.tvalid && rx.tready;
    assign drop_ev   = rx.tvalid && !rx.tready;

    assign bad_route = !rx.tdata[TGT_LSB + PORT_ID];
    assign bad_src   = ($countones(rx.tdata[SRC_LSB +: 4]) != 1);
    assign bad_type  = (pkt_type_e'(rx.tuser) == PKT_RESERVED);
    assign legal     = !bad_route && !bad_src && !bad_type;
    assign push      = accept && legal;
    assign src_idx   = onehot_to_idx(rx.tdata[SRC_LSB +: 4]);

    assign out.tvalid = fifo_valid && (state_q == RUN);
    assign out.tdata  = fifo_head[PACKET_WIDTH-1:0];
    assign out.tuser  = fifo_head[QW-1 -: 2];
    assign pop        = out.tvalid && out.tready;

    switch_port_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (QW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({rx.tuser, rx.tdata}),
        .pop       (pop),
        .flush     (flush_req),
        .full      (fifo_full),
        .valid     (fifo_valid),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req)  state_d = FLUSH;
            FLUSH:   if (!flush_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Saturating statistics; a coincident clear overrides every update.
    always_comb begin
        src_cnt_d      = src_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        err_cnt_d      = err_cnt_q;
        err_misroute_d = err_misroute_q;
        err_src_d      = err_src_q;
        err_type_d     = err_type_q;
        if (drop_ev && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        if (push && src_cnt_q[src_idx] != '1) src_cnt_d[src_idx] = src_cnt_q[src_idx] + CNT_WIDTH'(1);
        if (accept && !legal) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            err_misroute_d = err_misroute_q | bad_route;
            err_src_d      = err_src_q | bad_src;
            err_type_d     = err_type_q | bad_type;
        end
        if (stat_clr) begin
            src_cnt_d      = '0;
            drop_cnt_d     = '0;
            err_cnt_d      = '0;
            err_misroute_d = 1'b0;
            err_src_d      = 1'b0;
            err_type_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            live_q         <= 1'b0;
            src_cnt_q      <= '0;
            drop_cnt_q     <= '0;
            err_cnt_q      <= '0;
            err_misroute_q <= 1'b0;
            err_src_q      <= 1'b0;
            err_type_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            live_q         <= live_d;
            src_cnt_q      <= src_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            err_cnt_q      <= err_cnt_d;
            err_misroute_q <= err_misroute_d;
            err_src_q      <= err_src_d;
            err_type_q     <= err_type_d;
        end
    end

    assign src_cnt      = src_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign err_misroute = err_misroute_q;
    assign err_src      = err_src_q;
    assign err_type     = err_type_q;

endmodule
